// File: rtl/avalon_st_pkg.sv
// Shared types and length helpers for the Avalon-ST packet source.
package avalon_st_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } avst_src_state_t;

    localparam int unsigned AVST_BYTES_PER_BEAT = 32'd8;

    function automatic int unsigned avst_beats(
        input int unsigned len,
        input int unsigned bpb = AVST_BYTES_PER_BEAT
    );
        return (len + bpb - 32'd1) / bpb;
    endfunction

    function automatic int unsigned avst_empty(
        input int unsigned len,
        input int unsigned bpb = AVST_BYTES_PER_BEAT
    );
        return (bpb - (len % bpb)) % bpb;
    endfunction

endpackage

// File: rtl/avalon_st_source.sv
// Avalon-ST packet source: one command in, one SOP..EOP packet out with backpressure.
// Optional feature macro: AVST_SRC_PKT_COUNT_EN adds a 32-bit pkt_count output.
module avalon_st_source
    import avalon_st_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int MAX_BEATS   = 4,
    parameter int EMPTY_WIDTH = $clog2(WIDTH/8),
    parameter int LEN_WIDTH   = $clog2(MAX_BEATS*WIDTH/8+1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [LEN_WIDTH-1:0]              cmd_len,
    input  logic [MAX_BEATS-1:0][WIDTH-1:0]   cmd_payload,
    output logic                              cmd_err,
    output logic [WIDTH-1:0]                  data,
    output logic                              valid,
    input  logic                              ready,
    output logic                              sop,
    output logic                              eop,
    output logic [EMPTY_WIDTH-1:0]            empty,
    output logic                              busy,
    output logic                              pkt_done
`ifdef AVST_SRC_PKT_COUNT_EN
    ,
    output logic [31:0]                       pkt_count
`endif
);

    localparam int unsigned BPB       = WIDTH / 8;
    localparam int unsigned MAX_BYTES = MAX_BEATS * BPB;
    localparam int          IDX_WIDTH = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef logic [MAX_BEATS-1:0][WIDTH-1:0] payload_t;

    avst_src_state_t         state_r, state_s;
    payload_t                payload_r, payload_s;
    logic [IDX_WIDTH-1:0]    idx_r, idx_s;
    logic [IDX_WIDTH-1:0]    last_idx_r, last_idx_s;
    logic [EMPTY_WIDTH-1:0]  last_empty_r, last_empty_s;
    logic                    len_legal_s;
    logic                    cmd_err_s, pkt_done_s;

    logic                    valid_r, valid_s;
    logic [WIDTH-1:0]        data_r, data_s;
    logic                    sop_r, sop_s;
    logic                    eop_r, eop_s;
    logic [EMPTY_WIDTH-1:0]  empty_r, empty_s;
    logic                    busy_r, busy_s;
    logic                    cmd_ready_r, cmd_ready_s;
    logic                    cmd_err_r, pkt_done_r;

    assign len_legal_s = (cmd_len != {LEN_WIDTH{1'b0}}) &&
                         (cmd_len <= LEN_WIDTH'(MAX_BYTES));

    // Next-state logic: command acceptance in IDLE, beat advance on transfer in SEND.
    always_comb begin
        state_s      = state_r;
        payload_s    = payload_r;
        idx_s        = idx_r;
        last_idx_s   = last_idx_r;
        last_empty_s = last_empty_r;
        cmd_err_s    = 1'b0;
        pkt_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (len_legal_s) begin
                        payload_s    = cmd_payload;
                        idx_s        = {IDX_WIDTH{1'b0}};
                        last_idx_s   = IDX_WIDTH'(avst_beats(32'(cmd_len), BPB) - 32'd1);
                        last_empty_s = EMPTY_WIDTH'(avst_empty(32'(cmd_len), BPB));
                        state_s      = SEND;
                    end else begin
                        cmd_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (ready) begin
                    if (idx_r == last_idx_r) begin
                        state_s    = IDLE;
                        pkt_done_s = 1'b1;
                    end else begin
                        idx_s = idx_r + IDX_WIDTH'(1);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from next state so every port comes straight from a flop.
    always_comb begin
        valid_s     = (state_s == SEND);
        cmd_ready_s = (state_s == IDLE);
        busy_s      = valid_s;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        empty_s     = {EMPTY_WIDTH{1'b0}};
        data_s      = {WIDTH{1'b0}};
        if (valid_s) begin
            data_s = payload_s[idx_s];
            sop_s  = (idx_s == {IDX_WIDTH{1'b0}});
            eop_s  = (idx_s == last_idx_s);
            if (eop_s) begin
                empty_s = last_empty_s;
            end else begin
                empty_s = {EMPTY_WIDTH{1'b0}};
            end
        end else begin
            data_s = {WIDTH{1'b0}};
        end
    end

    // State, datapath and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            payload_r    <= {(MAX_BEATS*WIDTH){1'b0}};
            idx_r        <= {IDX_WIDTH{1'b0}};
            last_idx_r   <= {IDX_WIDTH{1'b0}};
            last_empty_r <= {EMPTY_WIDTH{1'b0}};
            valid_r      <= 1'b0;
            data_r       <= {WIDTH{1'b0}};
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            empty_r      <= {EMPTY_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            cmd_ready_r  <= 1'b1;
            cmd_err_r    <= 1'b0;
            pkt_done_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            payload_r    <= payload_s;
            idx_r        <= idx_s;
            last_idx_r   <= last_idx_s;
            last_empty_r <= last_empty_s;
            valid_r      <= valid_s;
            data_r       <= data_s;
            sop_r        <= sop_s;
            eop_r        <= eop_s;
            empty_r      <= empty_s;
            busy_r       <= busy_s;
            cmd_ready_r  <= cmd_ready_s;
            cmd_err_r    <= cmd_err_s;
            pkt_done_r   <= pkt_done_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign cmd_err   = cmd_err_r;
    assign data      = data_r;
    assign valid     = valid_r;
    assign sop       = sop_r;
    assign eop       = eop_r;
    assign empty     = empty_r;
    assign busy      = busy_r;
    assign pkt_done  = pkt_done_r;

`ifdef AVST_SRC_PKT_COUNT_EN
    logic [31:0] pkt_count_r;

    // Completed-packet counter, stepped in the same edge that raises pkt_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_r <= 32'd0;
        end else if (pkt_done_s) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_avalon_st_source.sv
// Randomized self-checking bench for avalon_st_source against a beat-queue reference model.
module tb_avalon_st_source;

    localparam int WIDTH       = 64;
    localparam int MAX_BEATS   = 4;
    localparam int EMPTY_WIDTH = 3;
    localparam int LEN_WIDTH   = 6;

    typedef logic [MAX_BEATS-1:0][WIDTH-1:0] payload_t;
    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [LEN_WIDTH-1:0]   cmd_len;
    payload_t               cmd_payload;
    logic                   cmd_err;
    logic [WIDTH-1:0]       data;
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   busy;
    logic                   pkt_done;
`ifdef AVST_SRC_PKT_COUNT_EN
    logic [31:0]            pkt_count;
`endif

    always #5 clk = ~clk;

    avalon_st_source dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_payload(cmd_payload), .cmd_err(cmd_err),
        .data(data), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .empty(empty), .busy(busy), .pkt_done(pkt_done)
`ifdef AVST_SRC_PKT_COUNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    int    pkts_done = 0;
    bit    accepted = 1'b0;
    bit    exp_err = 1'b0;
    bit    exp_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: split len bytes into 8-byte beats, remaining bytes decide EOP and empty.
    task automatic model_push(input int len, input payload_t p);
        int    rem = len;
        int    i = 0;
        beat_t b;
        while (rem > 0) begin
            b.data  = p[i];
            b.sop   = (i == 0);
            rem     = rem - 8;
            b.eop   = (rem <= 0);
            b.empty = b.eop ? 3'(-rem) : 3'd0;
            exp_q.push_back(b);
            i++;
        end
    endtask

    // One clock: set ready, compare outputs with the model, update the model, advance.
    task automatic tick();
        cyc++;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ((cyc % 5) != 4);
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
        check_eq("cmd_err", cmd_err, exp_err);
        check_eq("pkt_done", pkt_done, exp_done);
        exp_err  = 1'b0;
        exp_done = 1'b0;
        check_eq("busy", busy, exp_q.size() != 0);
        check_eq("cmd_ready", cmd_ready, exp_q.size() == 0);
        if (exp_q.size() != 0) begin
            check_eq("valid", valid, 1'b1);
            check_eq("data", data, exp_q[0].data);
            check_eq("sop", sop, exp_q[0].sop);
            check_eq("eop", eop, exp_q[0].eop);
            check_eq("empty", empty, exp_q[0].empty);
        end else begin
            check_eq("valid_idle", valid, 1'b0);
        end
        accepted = 1'b0;
        if (rst) begin
            exp_q.delete();
            pkts_done = 0;
        end else if (exp_q.size() != 0 && ready) begin
            if (exp_q[0].eop) begin
                exp_done = 1'b1;
                pkts_done++;
            end
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0 && cmd_valid) begin
            accepted = 1'b1;
            if (cmd_len >= 6'd1 && cmd_len <= 6'd32) begin
                model_push(int'(cmd_len), cmd_payload);
            end else begin
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int len, input payload_t p);
        int n = 0;
        cmd_len     = LEN_WIDTH'(len);
        cmd_payload = p;
        cmd_valid   = 1'b1;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) check_eq("accept_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || exp_done || exp_err) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check_eq("idle_timeout", 64'd0, 64'd1);
    endtask

    function automatic payload_t rand_payload();
        payload_t p;
        for (int i = 0; i < MAX_BEATS; i++) p[i] = {$urandom, $urandom};
        return p;
    endfunction

    initial begin
        payload_t p;
        int       len;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        cmd_payload = '0;
        ready       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sop", sop, 1'b0);
        check_eq("rst_eop", eop, 1'b0);
        check_eq("rst_cmd_err", cmd_err, 1'b0);
        check_eq("rst_pkt_done", pkt_done, 1'b0);
        check_eq("rst_data", data, 64'd0);
`ifdef AVST_SRC_PKT_COUNT_EN
        check_eq("rst_pkt_count", pkt_count, 64'd0);
`endif
        rst = 1'b0;

        // Full 32-byte packet with the fixed word pattern, sink always ready.
        p[0] = 64'h1111_1111_1111_1111;
        p[1] = 64'h2222_2222_2222_2222;
        p[2] = 64'h3333_3333_3333_3333;
        p[3] = 64'h4444_4444_4444_4444;
        send(32, p);
        wait_idle();
        send(13, rand_payload());
        wait_idle();
        send(1, rand_payload());
        wait_idle();
`ifdef AVST_SRC_PKT_COUNT_EN
        check_eq("pkt_count3", pkt_count, 64'(pkts_done));
        check_eq("pkt_count_is3", 64'(pkts_done), 64'd3);
`endif

        // Periodic stall on every 5th cycle.
        ready_mode = 1;
        send(32, p);
        wait_idle();
        send(20, rand_payload());
        wait_idle();

        // Illegal lengths pulse cmd_err and emit nothing.
        ready_mode = 0;
        send(0, rand_payload());
        wait_idle();
        send(33, rand_payload());
        wait_idle();

        // cmd_valid held across a packet: next packet only after return to IDLE.
        cmd_len     = 6'd16;
        cmd_payload = rand_payload();
        cmd_valid   = 1'b1;
        repeat (12) tick();
        cmd_valid = 1'b0;
        wait_idle();

        // Reset after beat 1 of a 4-beat packet.
        send(32, rand_payload());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid", valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 1'b1);
`ifdef AVST_SRC_PKT_COUNT_EN
        check_eq("mid_rst_pkt_count", pkt_count, 64'd0);
`endif
        tick();
        send(8, rand_payload());
        wait_idle();

        // Randomized lengths, payloads, gaps and backpressure.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63));
            end else begin
                len = int'($urandom_range(1, 32));
            end
            send(len, rand_payload());
            if ($urandom_range(0, 2) == 0) wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        tick();
`ifdef AVST_SRC_PKT_COUNT_EN
        check_eq("pkt_count_final", pkt_count, 64'(pkts_done));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_st_source.md
# avalon_st_source

Avalon-ST packet source feeding `avalon_st_sink`. Accepts one command carrying a byte length and up to `MAX_BEATS` payload words. Streams the payload as a single SOP…EOP packet on a 64-bit ready-latency-0 Avalon-ST interface, honouring backpressure. Sits between the test/control logic and the sink; it is the traffic generator for the streaming datapath.

## Interface
- `WIDTH`, 64: data bus width in bits, a multiple of 8.
- `MAX_BEATS`, 4: payload words per packet.
- `EMPTY_WIDTH`, `$clog2(WIDTH/8)`: width of `empty`.
- `LEN_WIDTH`, `$clog2(MAX_BEATS*WIDTH/8+1)`: width of `cmd_len`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_len` in `LEN_WIDTH`: packet length in bytes; legal range 1..`MAX_BEATS*WIDTH/8`.
- `cmd_payload` in `[MAX_BEATS-1:0][WIDTH-1:0]`: beat i carries `cmd_payload[i]`.
- `cmd_err` out 1: one-cycle pulse when an illegal command is accepted.
- `data` out `WIDTH`: stream data.
- `valid` out 1: beat present.
- `ready` in 1: sink can take the beat; a beat transfers on any cycle with `valid && ready`.
- `sop` out 1: first beat of packet.
- `eop` out 1: last beat of packet.
- `empty` out `EMPTY_WIDTH`: unused bytes in the EOP beat; 0 on all other beats.
- `busy` out 1: a packet is in flight.
- `pkt_done` out 1: one-cycle pulse after the EOP beat transfers.

## Operation
- States: IDLE, SEND.
- IDLE:
  - `cmd_ready=1`.
  - On accept with a legal length: latch payload; set beats = ceil(len/8) and `last_empty = (8 - len%8) % 8`; clear the beat index; go to SEND.
  - On accept with `cmd_len==0` or `cmd_len > MAX_BEATS*WIDTH/8`: pulse `cmd_err`, stay in IDLE, emit nothing.
- SEND:
  - `valid=1`, `cmd_ready=0`, `busy=1`.
  - `data=payload[idx]`, `sop=(idx==0)`, `eop=(idx==beats-1)`, `empty=eop?last_empty:0`.
  - On transfer: if not EOP, increment idx; if EOP, go to IDLE and pulse `pkt_done`.
- Backpressure: while `valid && !ready`, `data`, `sop`, `eop` and `empty` hold stable. `valid` never deasserts mid-packet.
- Single-beat packet: `sop` and `eop` are both 1 on the same beat.
- `cmd_valid` while in SEND is ignored, since `cmd_ready=0`.
- Reset: at the first clock edge with `rst` high, all outputs go to 0 except `cmd_ready`, which goes to 1. State returns to IDLE; latched payload and index are cleared. A packet in flight is abandoned with no EOP, and no `pkt_done` is pulsed.

## Timing
- Command accepted at edge N: `valid`/`sop` high from edge N+1.
- Each beat: 1 cycle when `ready=1`; zero-bubble streaming.
- EOP transfers at edge M: `valid=0`, `pkt_done=1`, `cmd_ready=1` from edge M+1.
- Minimum spacing: one idle cycle between packets. A command accepted at M+1 gives its SOP at M+2.
- `cmd_err` is high during cycle N+1 only.
- All outputs are registered or decoded from registered state only. There is no combinational path from `ready` or `cmd_valid` to any output.

## Configuration
- `AVST_SRC_PKT_COUNT_EN`:
  - Defined: adds output `pkt_count` (32 bits, resets to 0), incremented with every `pkt_done`. It wraps from 0xFFFFFFFF to 0.
  - Undefined: the port and counter are absent.
  - All other behaviour is identical in both builds.

## Structure
- Package `avalon_st_pkg`:
  - state enum `avst_src_state_t` (IDLE, SEND);
  - function `avst_empty(len)`;
  - function `avst_beats(len)`;
  - constant `AVST_BYTES_PER_BEAT`.
- Single module, no sub-module; the datapath is a payload register plus a beat index.

## Test plan
- Sink `ready` always 1, `cmd_len=32`, payload words 0x11..11, 0x22..22, 0x33..33, 0x44..44 → 4 consecutive beats, SOP on beat 0, EOP on beat 3, `empty=0`, `pkt_done` one cycle after beat 3.
- `cmd_len=13` → 2 beats, EOP beat `empty=3`; `cmd_len=1` → one beat with SOP=EOP=1 and `empty=7`.
- `ready` low on every 5th cycle (sink pattern, counter==4), 32-byte packet → beats held stable during stalls, no beat lost or duplicated, order 0..3 preserved.
- `cmd_len=0`, then `cmd_len=33` → `cmd_err` pulses twice, `valid` stays 0; `cmd_valid` held during SEND → no second packet until IDLE.
- `rst` asserted mid-packet after beat 1 → next cycle `valid=0`, `busy=0`, `cmd_ready=1`; a following 8-byte command streams normally with SOP.
- `AVST_SRC_PKT_COUNT_EN` build, 3 packets sent → `pkt_count=3`; after reset `pkt_count=0`.
